conv_frame_scheduler: RTL

- Sequences one 3x3 grayscale convolution filter instance across a full IMG_W x IMG_H frame.
- Holds a double-buffered kernel bank: host writes a shadow copy, and the shadow is committed to the active copy at frame boundaries.
- Issues window-fetch requests in raster order, gates the filter's input valid, and tags filter outputs with output coordinates.
- Sits between the host configuration bus, the window-fetch/line-buffer unit and the filter.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_kernel_bank.sv | 71 +++++++
 rtl/conv_frame_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution frame scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  typedef logic [2:0][2:0][15:0] kernel_t;

  localparam int TAP_IDX_W = 4;

  // Tap 4 (centre) = 1.0 in the filter's fixed-point format, all others 0.
  localparam kernel_t KERNEL_IDENTITY = {64'h0, 16'h0010, 64'h0};

  function automatic logic [TAP_IDX_W-1:0] tap_index(input int row, input int col);
    return TAP_IDX_W'(row * 3 + col);
  endfunction

endpackage

// File: rtl/conv_kernel_bank.sv
// Double-buffered kernel store: host writes the shadow copy, swap to active only from IDLE.
module conv_kernel_bank
  import conv_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [TAP_IDX_W-1:0] cfg_addr_i,
  input  logic [15:0]          cfg_data_i,
  input  logic                 cfg_commit_i,
  input  logic                 idle_i,
  input  logic                 start_i,
  output kernel_t              active_o
);

  kernel_t shadow_q, shadow_d;
  kernel_t active_q, active_d;
  logic    pending_q, pending_d;
  logic    swap_s;

  // A commit seen outside IDLE is deferred to the next frame start.
  assign swap_s = idle_i & (cfg_commit_i | (start_i & pending_q));

  // Shadow tap write decode; addresses 9..15 match no tap.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (cfg_addr_i == tap_index(r, c)) begin
            shadow_d[r][c] = cfg_data_i;
          end else begin
            shadow_d[r][c] = shadow_q[r][c];
          end
        end
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Swap and pending-commit bookkeeping.
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    if (swap_s) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (cfg_commit_i && !idle_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Kernel bank state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= KERNEL_IDENTITY;
      active_q  <= KERNEL_IDENTITY;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/conv_frame_scheduler.sv
// Raster-order window scheduler for one 3x3 filter with in-flight limit and output tagging.
// Optional CONV_PERF_CNT_EN adds perf_cycles_o / perf_stall_o counters.
module conv_frame_scheduler
  import conv_pkg::*;
#(
  parameter int  IMG_W        = 28,
  parameter int  IMG_H        = 28,
  parameter int  MAX_INFLIGHT = 8,
  localparam int CW           = $clog2(IMG_H),
  localparam int CWC          = $clog2(IMG_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [TAP_IDX_W-1:0] cfg_addr_i,
  input  logic [15:0]          cfg_data_i,
  input  logic                 cfg_commit_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 win_req_o,
  output logic [CW-1:0]        win_row_o,
  output logic [CWC-1:0]       win_col_o,
  input  logic                 win_ready_i,
  output logic                 flt_valid_o,
  output kernel_t              flt_k_o,
  input  logic                 flt_valid_i,
  output logic                 out_we_o,
  output logic [CW-1:0]        out_row_o,
  output logic [CWC-1:0]       out_col_o
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0]          perf_cycles_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);
  localparam int IFW  = $clog2(MAX_INFLIGHT + 1);
  localparam int RCW  = $clog2(NWIN + 1);

  conv_state_e    state_q, state_d;
  logic [CW-1:0]  row_q, row_d, orow_q, orow_d;
  logic [CWC-1:0] col_q, col_d, ocol_q, ocol_d;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic [RCW-1:0] rcv_q, rcv_d;
  logic           err_q, err_d;
  logic           idle_s, busy_s, start_acc_s, win_req_s, accept_s, out_ok_s, last_win_s;

  assign idle_s      = (state_q == IDLE);
  assign busy_s      = (state_q == ISSUE) || (state_q == DRAIN);
  assign start_acc_s = idle_s & start_i;
  // A returning output frees a slot in the same cycle, so a full pipe may still issue.
  assign win_req_s   = (state_q == ISSUE) & ((inflight_q < IFW'(MAX_INFLIGHT)) | flt_valid_i);
  assign accept_s    = win_req_s & win_ready_i;
  assign out_ok_s    = busy_s & flt_valid_i & (inflight_q != {IFW{1'b0}});
  assign last_win_s  = (row_q == CW'(IMG_H - 3)) && (col_q == CWC'(IMG_W - 3));

  conv_kernel_bank u_kernel_bank (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_commit_i (cfg_commit_i),
    .idle_i       (idle_s),
    .start_i      (start_i),
    .active_o     (flt_k_o)
  );

  // Window, output-tag, in-flight and received counters.
  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    inflight_d = inflight_q;
    rcv_d      = rcv_q;
    if (start_acc_s) begin
      row_d      = {CW{1'b0}};
      col_d      = {CWC{1'b0}};
      orow_d     = {CW{1'b0}};
      ocol_d     = {CWC{1'b0}};
      inflight_d = {IFW{1'b0}};
      rcv_d      = {RCW{1'b0}};
    end else begin
      if (accept_s) begin
        if (col_q == CWC'(IMG_W - 3)) begin
          col_d = {CWC{1'b0}};
          row_d = row_q + CW'(1);
        end else begin
          col_d = col_q + CWC'(1);
        end
      end else begin
        col_d = col_q;
      end
      if (out_ok_s) begin
        rcv_d = rcv_q + RCW'(1);
        if (ocol_q == CWC'(IMG_W - 3)) begin
          ocol_d = {CWC{1'b0}};
          orow_d = orow_q + CW'(1);
        end else begin
          ocol_d = ocol_q + CWC'(1);
        end
      end else begin
        rcv_d = rcv_q;
      end
      case ({accept_s, out_ok_s})
        2'b10:   inflight_d = inflight_q + IFW'(1);
        2'b01:   inflight_d = inflight_q - IFW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Frame FSM next state and sticky protocol error.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (accept_s && last_win_s) state_d = DRAIN; else state_d = ISSUE;
      DRAIN:   if (rcv_d == RCW'(NWIN)) state_d = DONE; else state_d = DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((start_i && busy_s) || (flt_valid_i && !out_ok_s)) begin
      err_d = 1'b1;
    end else if (start_acc_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_q      <= {CW{1'b0}};
      col_q      <= {CWC{1'b0}};
      orow_q     <= {CW{1'b0}};
      ocol_q     <= {CWC{1'b0}};
      inflight_q <= {IFW{1'b0}};
      rcv_q      <= {RCW{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      inflight_q <= inflight_d;
      rcv_q      <= rcv_d;
      err_q      <= err_d;
    end
  end

  assign busy_o      = busy_s;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign win_req_o   = win_req_s;
  assign win_row_o   = row_q;
  assign win_col_o   = col_q;
  assign flt_valid_o = accept_s;
  assign out_we_o    = out_ok_s;
  assign out_row_o   = orow_q;
  assign out_col_o   = ocol_q;

`ifdef CONV_PERF_CNT_EN
  logic [31:0] pcyc_q, pcyc_d, pstall_q, pstall_d;

  // Every non-accepting ISSUE cycle is a stall: either fetch not ready or in-flight limit.
  always_comb begin
    pcyc_d   = pcyc_q;
    pstall_d = pstall_q;
    if (start_acc_s) begin
      pcyc_d   = 32'd1;
      pstall_d = 32'd0;
    end else if (!idle_s) begin
      pcyc_d = pcyc_q + 32'd1;
      if ((state_q == ISSUE) && !accept_s) begin
        pstall_d = pstall_q + 32'd1;
      end else begin
        pstall_d = pstall_q;
      end
    end else begin
      pcyc_d   = pcyc_q;
      pstall_d = pstall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcyc_q   <= 32'd0;
      pstall_q <= 32'd0;
    end else begin
      pcyc_q   <= pcyc_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_cycles_o = pcyc_q;
  assign perf_stall_o  = pstall_q;
`endif

endmodule
